mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Merges the two CPU-side memory ports into one physical memory port.
  - Port A: read-only instruction fetch.
  - Port B: read/write data.
- Sits between the core (or its caches) and the shared memory model / cacheline adapter.
- Serialises requests, holds the winning transaction stable until the memory responds, then returns data and a one-cycle response to the winner only.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports; mask width is DATA_W/8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- read_a  input  1  port A read request, held until resp_a.
- address_a  input  ADDR_W  port A address.
- resp_a  output  1  port A done, one-cycle pulse.
- rdata_a  output  DATA_W  port A read data, valid while resp_a=1.
- read_b  input  1  port B read request, held until resp_b.
- write  input  1  port B write request, held until resp_b.
- wmask  input  DATA_W/8  port B byte enables.
- address_b  input  ADDR_W  port B address.
- wdata  input  DATA_W  port B write data.
- resp_b  output  1  port B done, one-cycle pulse.
- rdata_b  output  DATA_W  port B read data, valid while resp_b=1.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_wmask  output  DATA_W/8  memory byte enables.
- mem_address  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_resp  input  1  memory done, one-cycle pulse.
- mem_rdata  input  DATA_W  memory read data, valid with mem_resp.

Behaviour:
- Reset values (cycle after rst sampled high): state=IDLE; all resp_*, mem_read, mem_write = 0; mem_address, mem_wdata, mem_wmask, rdata_a, rdata_b = 0.
- State machine: IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B.
- IDLE:
  - Port A pending when read_a=1.
  - Port B pending when read_b|write = 1.
  - Only A pending -> SERVE_A.
  - Only B pending -> SERVE_B.
  - Both pending -> SERVE_B (fixed data priority; see Optional Feature).
  - On that edge, latch into registers: address, wdata, wmask, and op (read or write).
- SERVE_x:
  - mem_read / mem_write driven from the latched op; mem_address, mem_wdata and mem_wmask driven from the latched registers.
  - Requester inputs are ignored while in SERVE_x.
  - Stays in SERVE_x until mem_resp=1.
  - On mem_resp: latch mem_rdata into rdata_x, go to DONE_x, and deassert mem_read/mem_write on that same edge.
- DONE_x: resp_x=1 for exactly this cycle, then -> IDLE.
  - The requester deasserts its request on seeing resp_x, so it is low by the time IDLE samples.
- Latency:
  - Request seen in IDLE at cycle 0; strobe asserted from cycle 1.
  - mem_resp in cycle k -> resp_x in cycle k+1.
  - Minimum turnaround is 3 cycles; back-to-back transactions are spaced by at least one IDLE cycle.
- Port B op encoding: write=1 is a write, regardless of read_b. read_b=1 with write=0 is a read.
- Write transactions: rdata_b is updated with mem_rdata as for reads; the value is undefined for the requester.
- rdata_x holds its last value outside DONE_x. The non-winning port sees resp=0 throughout.
- mem_read and mem_write are never both 1. Exactly one of them is 1 in every SERVE cycle.
- mem_resp outside SERVE_x is ignored (no state change, no resp pulse).
- A request dropped mid-SERVE is still completed, and its resp pulse is still issued.
- rst mid-transaction: the next state is IDLE, strobes drop the next cycle, and the pending memory response is discarded.
  - The memory model is also reset.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register, reset value A.
  - On contention in IDLE, grant the port not granted last; last_grant updates on every grant.
  - Contention is never starved: two contended grants in a row always alternate.
- Undefined:
  - Fixed priority, port B always wins contention.
  - No last_grant register exists.

Test Plan:
- Reset, then read_a=1, address_a=0x60: mem_read=1 with mem_address=0x60 from cycle 1. mem_resp=1 with mem_rdata=0x00000013 at cycle 3 -> resp_a=1 and rdata_a=0x00000013 at cycle 4 only; resp_b=0 throughout.
- write=1, address_b=0x100, wdata=0xDEADBEEF, wmask=4'b0011: mem_write=1, mem_read=0, mem_address=0x100, mem_wdata=0xDEADBEEF, mem_wmask=0011. mem_resp -> resp_b one-cycle pulse.
- read_a and read_b raised in the same cycle:
  - Without macro: port B served first; A served after resp_b, with ≥1 IDLE cycle between.
  - With macro, after a prior grant to B: A served first.
- Request at 0x200; mem_resp held low 20 cycles: mem_address/mem_read stable all 20 cycles even after address_b changes to 0x300. resp_b follows mem_resp by exactly 1 cycle.
- rst asserted in SERVE_A cycle 2: mem_read=0 next cycle; no resp_a pulse; a later mem_resp is ignored.
- Spurious mem_resp=1 in IDLE with no requests -> no resp_a/resp_b; state remains IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges an instruction-fetch read port (A) and a data
// read/write port (B) onto one memory port. A winning request is latched and
// held on the memory side until mem_resp, then the winner gets a one-cycle
// resp pulse with the returned data.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, contention
// alternates between the ports. When it is undefined, port B always wins
// contention.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_a,
    input  logic [ADDR_W-1:0]   address_a,
    output logic                resp_a,
    output logic [DATA_W-1:0]   rdata_a,
    input  logic                read_b,
    input  logic                write,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic [ADDR_W-1:0]   address_b,
    input  logic [DATA_W-1:0]   wdata,
    output logic                resp_b,
    output logic [DATA_W-1:0]   rdata_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B} state_t;

    state_t              state, state_nxt;
    logic                op_write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic                req_a, req_b, grant_b, grant_any;

    assign req_a     = read_a;
    assign req_b     = read_b | write;
    assign grant_any = (state == IDLE) && (req_a || req_b);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 0 = A was granted last, 1 = B was granted last
    logic last_grant;

    // On contention hand the grant to whichever port did not get the last one
    assign grant_b = req_b && (!req_a || !last_grant);

    // Remember the most recent winner
    always_ff @(posedge clk) begin
        if (rst)            last_grant <= 1'b0;
        else if (grant_any) last_grant <= grant_b;
    end
`else
    // Data port has fixed priority over instruction fetch
    assign grant_b = req_b;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe/response decode
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        resp_a    = 1'b0;
        resp_b    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_b)    state_nxt = SERVE_B;
                else if (req_a) state_nxt = SERVE_A;
            end
            SERVE_A: begin
                mem_read  = !op_write_q;
                mem_write = op_write_q;
                if (mem_resp) state_nxt = DONE_A;
            end
            SERVE_B: begin
                mem_read  = !op_write_q;
                mem_write = op_write_q;
                if (mem_resp) state_nxt = DONE_B;
            end
            DONE_A: begin
                resp_a    = 1'b1;
                state_nxt = IDLE;
            end
            DONE_B: begin
                resp_b    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winning request so the memory side stays stable while serving
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (grant_any) begin
            if (grant_b) begin
                op_write_q <= write;
                addr_q     <= address_b;
                wdata_q    <= wdata;
                wmask_q    <= wmask;
            end else begin
                op_write_q <= 1'b0;
                addr_q     <= address_a;
                wdata_q    <= '0;
                wmask_q    <= '0;
            end
        end
    end

    // Return data is captured only for the port being served
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (mem_resp) begin
            if (state == SERVE_A) rdata_a <= mem_rdata;
            if (state == SERVE_B) rdata_b <= mem_rdata;
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wmask   = wmask_q;

endmodule
